// File: rtl/dma_desc_ctl.sv
// -----------------------------------------------------------------------------
// dma_desc_ctl
//
// Descriptor-chain controller for the DMA engine. Takes the host-programmed
// control bits from the register block, fetches 4-word descriptors over a
// Wishbone master port, offers each descriptor to the data mover through a
// valid/ready handshake and then follows the chain pointer.
//
// Descriptor layout at 8-byte-aligned address A:
//   A+0  : [31:3] next pointer, [0] end of chain
//   A+4  : [15:0] ctl, [16] int_en
//   A+8  : buffer address
//   A+12 : [23:0] length
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for enable with a fresh ndar
// FETCH  | reading the four descriptor words, one beat at a time
// ISSUE  | descriptor offered to the data mover (desc_valid high)
// RUN    | data mover busy, waiting for desc_done
// NEXT   | decide: follow chain pointer or halt at end of chain
// HALT   | parked at end of chain, waiting for new ndar or append
// RELOAD | re-reading word0 of the current descriptor after an append
// ERROR  | bus or descriptor error, waiting for enable to drop
//
// Ports
//   wb_clk_i, wb_rst_i          clock, synchronous active-high reset
//   enable, append, ndar,
//   ndar_dirty, wb_int_clear    control from the register block
//   ndar_dirty_clear,
//   append_clear                one-cycle consume pulses to the register block
//   dar, next_desc, csr, busy,
//   wb_int_o, ctrl_state        status back to the register block
//   wbm_*                       Wishbone master (read only)
//   desc_valid/ready, desc_ctl,
//   desc_addr, desc_len         descriptor handoff to the data mover
//   desc_done, desc_err         transfer completion from the data mover
// -----------------------------------------------------------------------------
module dma_desc_ctl (
    input  logic         wb_clk_i,
    input  logic         wb_rst_i,
    input  logic         enable,
    input  logic         append,
    input  logic [31:3]  ndar,
    input  logic         ndar_dirty,
    input  logic         wb_int_clear,
    output logic         ndar_dirty_clear,
    output logic         append_clear,
    output logic [31:0]  dar,
    output logic [31:3]  next_desc,
    output logic [7:0]   csr,
    output logic         busy,
    output logic         wb_int_o,
    output logic [7:0]   ctrl_state,
    output logic [31:0]  wbm_adr_o,
    output logic         wbm_cyc_o,
    output logic         wbm_stb_o,
    output logic         wbm_we_o,
    output logic [3:0]   wbm_sel_o,
    input  logic [31:0]  wbm_dat_i,
    input  logic         wbm_ack_i,
    input  logic         wbm_err_i,
    output logic         desc_valid,
    input  logic         desc_ready,
    output logic [15:0]  desc_ctl,
    output logic [31:0]  desc_addr,
    output logic [23:0]  desc_len,
    input  logic         desc_done,
    input  logic         desc_err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_ISSUE  = 3'd2,
        S_RUN    = 3'd3,
        S_NEXT   = 3'd4,
        S_HALT   = 3'd5,
        S_RELOAD = 3'd6,
        S_ERROR  = 3'd7
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   dar_q, dar_d;
    logic [1:0]    idx_q, idx_d;
    logic [31:3]   next_q, next_d;
    logic          eoc_q, eoc_d;
    logic [15:0]   ctl_q, ctl_d;
    logic          int_en_q, int_en_d;
    logic [31:0]   addr_q, addr_d;
    logic [23:0]   len_q, len_d;
    logic [2:0]    csr_q, csr_d;
    logic          int_q, int_d;
    logic          cyc_q, cyc_d;
    logic [31:0]   adr_q, adr_d;
    logic          valid_q, valid_d;
    logic          dclr_q, dclr_d;
    logic          aclr_q, aclr_d;
    logic          busy_q, busy_d;
    logic          int_set;

    always_comb begin
        state_d  = state_q;
        dar_d    = dar_q;
        idx_d    = idx_q;
        next_d   = next_q;
        eoc_d    = eoc_q;
        ctl_d    = ctl_q;
        int_en_d = int_en_q;
        addr_d   = addr_q;
        len_d    = len_q;
        csr_d    = csr_q;
        cyc_d    = cyc_q;
        adr_d    = adr_q;
        dclr_d   = 1'b0;
        aclr_d   = 1'b0;
        int_set  = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Starting a fresh chain also drops the stale halted flag.
                if (enable && ndar_dirty) begin
                    dar_d    = {ndar, 3'b000};
                    dclr_d   = 1'b1;
                    idx_d    = 2'd0;
                    csr_d[0] = 1'b0;
                    state_d  = S_FETCH;
                end
            end

            S_FETCH: begin
                if (cyc_q) begin
                    if (wbm_err_i) begin
                        cyc_d    = 1'b0;
                        csr_d[1] = 1'b1;
                        int_set  = 1'b1;
                        state_d  = S_ERROR;
                    end else if (wbm_ack_i) begin
                        cyc_d = 1'b0;
                        idx_d = idx_q + 2'd1;
                        case (idx_q)
                            2'd0: begin
                                next_d = wbm_dat_i[31:3];
                                eoc_d  = wbm_dat_i[0];
                            end
                            2'd1: begin
                                ctl_d    = wbm_dat_i[15:0];
                                int_en_d = wbm_dat_i[16];
                            end
                            2'd2: addr_d = wbm_dat_i;
                            2'd3: len_d  = wbm_dat_i[23:0];
                        endcase
                        if (!enable)
                            state_d = S_IDLE;
                        else if (idx_q == 2'd3)
                            state_d = S_ISSUE;
                    end
                end else if (!enable) begin
                    state_d = S_IDLE;
                end else begin
                    // Beat offset wraps naturally in the 32-bit add.
                    cyc_d = 1'b1;
                    adr_d = dar_q + {28'd0, idx_q, 2'b00};
                end
            end

            S_ISSUE: begin
                if (valid_q && desc_ready)
                    state_d = S_RUN;
            end

            S_RUN: begin
                if (desc_done) begin
                    if (desc_err) begin
                        csr_d[2] = 1'b1;
                        int_set  = 1'b1;
                        state_d  = S_ERROR;
                    end else begin
                        int_set = int_en_q;
                        state_d = S_NEXT;
                    end
                end
            end

            S_NEXT: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (!eoc_q) begin
                    dar_d   = {next_q, 3'b000};
                    idx_d   = 2'd0;
                    state_d = S_FETCH;
                end else begin
                    csr_d[0] = 1'b1;
                    state_d  = S_HALT;
                end
            end

            S_HALT: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (ndar_dirty) begin
                    dar_d    = {ndar, 3'b000};
                    dclr_d   = 1'b1;
                    idx_d    = 2'd0;
                    csr_d[0] = 1'b0;
                    state_d  = S_FETCH;
                end else if (append) begin
                    aclr_d  = 1'b1;
                    state_d = S_RELOAD;
                end
            end

            S_RELOAD: begin
                if (cyc_q) begin
                    if (wbm_err_i) begin
                        cyc_d    = 1'b0;
                        csr_d[1] = 1'b1;
                        int_set  = 1'b1;
                        state_d  = S_ERROR;
                    end else if (wbm_ack_i) begin
                        cyc_d  = 1'b0;
                        next_d = wbm_dat_i[31:3];
                        eoc_d  = wbm_dat_i[0];
                        if (!enable) begin
                            state_d = S_IDLE;
                        end else if (!wbm_dat_i[0]) begin
                            csr_d[0] = 1'b0;
                            dar_d    = {wbm_dat_i[31:3], 3'b000};
                            idx_d    = 2'd0;
                            state_d  = S_FETCH;
                        end else begin
                            state_d = S_HALT;
                        end
                    end
                end else if (!enable) begin
                    state_d = S_IDLE;
                end else begin
                    cyc_d = 1'b1;
                    adr_d = dar_q;
                end
            end

            S_ERROR: begin
                if (!enable) begin
                    csr_d[2:1] = 2'b00;
                    state_d    = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase

        // A set wins over a simultaneous clear.
        int_d   = int_set | (int_q & ~wb_int_clear);
        valid_d = (state_d == S_ISSUE);
        busy_d  = !(state_d inside {S_IDLE, S_HALT, S_ERROR});
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q  <= S_IDLE;
            dar_q    <= 32'd0;
            idx_q    <= 2'd0;
            next_q   <= '0;
            eoc_q    <= 1'b0;
            ctl_q    <= 16'd0;
            int_en_q <= 1'b0;
            addr_q   <= 32'd0;
            len_q    <= 24'd0;
            csr_q    <= 3'd0;
            int_q    <= 1'b0;
            cyc_q    <= 1'b0;
            adr_q    <= 32'd0;
            valid_q  <= 1'b0;
            dclr_q   <= 1'b0;
            aclr_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            dar_q    <= dar_d;
            idx_q    <= idx_d;
            next_q   <= next_d;
            eoc_q    <= eoc_d;
            ctl_q    <= ctl_d;
            int_en_q <= int_en_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            csr_q    <= csr_d;
            int_q    <= int_d;
            cyc_q    <= cyc_d;
            adr_q    <= adr_d;
            valid_q  <= valid_d;
            dclr_q   <= dclr_d;
            aclr_q   <= aclr_d;
            busy_q   <= busy_d;
        end
    end

    assign ndar_dirty_clear = dclr_q;
    assign append_clear     = aclr_q;
    assign dar              = dar_q;
    assign next_desc        = next_q;
    assign csr              = {5'd0, csr_q};
    assign busy             = busy_q;
    assign wb_int_o         = int_q;
    assign ctrl_state       = {5'd0, state_q};
    assign wbm_adr_o        = adr_q;
    assign wbm_cyc_o        = cyc_q;
    assign wbm_stb_o        = cyc_q;
    assign wbm_we_o         = 1'b0;
    assign wbm_sel_o        = 4'hf;
    assign desc_valid       = valid_q;
    assign desc_ctl         = ctl_q;
    assign desc_addr        = addr_q;
    assign desc_len         = len_q;

endmodule

// File: tb/tb_dma_desc_ctl.sv
// -----------------------------------------------------------------------------
// tb_dma_desc_ctl
//
// Bench for dma_desc_ctl. A Wishbone memory slave with random wait states and
// a data mover with random ready delays surround the DUT. Expected bus reads,
// handed-off descriptors and final status are derived by walking the
// descriptor chain in the bench memory.
// -----------------------------------------------------------------------------
module tb_dma_desc_ctl;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         enable = 1'b0;
    logic         append = 1'b0;
    logic [31:3]  ndar = '0;
    logic         ndar_dirty = 1'b0;
    logic         wb_int_clear = 1'b0;
    logic         ndar_dirty_clear, append_clear;
    logic [31:0]  dar;
    logic [31:3]  next_desc;
    logic [7:0]   csr;
    logic         busy, wb_int_o;
    logic [7:0]   ctrl_state;
    logic [31:0]  wbm_adr_o;
    logic         wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]   wbm_sel_o;
    logic [31:0]  wbm_dat_i = 32'd0;
    logic         wbm_ack_i = 1'b0;
    logic         wbm_err_i = 1'b0;
    logic         desc_valid;
    logic         desc_ready = 1'b1;
    logic [15:0]  desc_ctl;
    logic [31:0]  desc_addr;
    logic [23:0]  desc_len;
    logic         desc_done = 1'b0;
    logic         desc_err = 1'b0;

    dma_desc_ctl dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .enable(enable), .append(append),
        .ndar(ndar), .ndar_dirty(ndar_dirty), .wb_int_clear(wb_int_clear),
        .ndar_dirty_clear(ndar_dirty_clear), .append_clear(append_clear),
        .dar(dar), .next_desc(next_desc), .csr(csr), .busy(busy),
        .wb_int_o(wb_int_o), .ctrl_state(ctrl_state),
        .wbm_adr_o(wbm_adr_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
        .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o), .wbm_dat_i(wbm_dat_i),
        .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i),
        .desc_valid(desc_valid), .desc_ready(desc_ready),
        .desc_ctl(desc_ctl), .desc_addr(desc_addr), .desc_len(desc_len),
        .desc_done(desc_done), .desc_err(desc_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] ctl;
        logic [31:0] addr;
        logic [23:0] len;
    } hs_t;

    logic [31:0] mem [logic [31:0]];
    logic [31:0] rd_q[$], exp_rd[$];
    hs_t         hs_q[$], exp_hs[$];
    logic        exp_int;
    logic [31:0] exp_dar;
    logic [28:0] exp_next;

    int n_tests = 0;
    int n_fail  = 0;
    int dclr_cnt = 0;
    int aclr_cnt = 0;
    int wait_max = 0;
    int wcnt = 0;
    bit hold = 1'b0;
    bit err_en = 1'b0;
    bit rdy_rand = 1'b0;
    logic [31:0] err_addr = 32'd0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] rd_mem(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'd0;
    endfunction

    task automatic put_desc(input logic [31:0] a, input logic [31:0] w0,
                            input logic [31:0] w1, input logic [31:0] w2,
                            input logic [31:0] w3);
        mem[a]         = w0;
        mem[a + 32'd4]  = w1;
        mem[a + 32'd8]  = w2;
        mem[a + 32'd12] = w3;
    endtask

    function automatic void exp_clear();
        exp_rd.delete();
        exp_hs.delete();
        exp_int  = 1'b0;
        exp_dar  = 32'd0;
        exp_next = 29'd0;
    endfunction

    // Walk the chain in bench memory the way the host sees it.
    function automatic void walk(input logic [31:0] start);
        logic [31:0] a, w0, w1;
        hs_t h;
        a = start;
        for (int k = 0; k < 16; k++) begin
            for (int j = 0; j < 4; j++) exp_rd.push_back(a + 32'(4 * j));
            w0 = rd_mem(a);
            w1 = rd_mem(a + 32'd4);
            h.ctl  = w1[15:0];
            h.addr = rd_mem(a + 32'd8);
            h.len  = rd_mem(a + 32'd12) & 24'hFF_FFFF;
            exp_hs.push_back(h);
            if (w1[16]) exp_int = 1'b1;
            exp_dar  = a;
            exp_next = w0[31:3];
            if (w0[0]) break;
            a = {w0[31:3], 3'b000};
        end
    endfunction

    // Memory slave: random wait states, optional error address, optional stall.
    always @(negedge clk) begin
        wbm_ack_i = 1'b0;
        wbm_err_i = 1'b0;
        if (wbm_cyc_o && wbm_stb_o && !rst && !hold) begin
            if (wcnt == 0) begin
                if (err_en && wbm_adr_o == err_addr) begin
                    wbm_err_i = 1'b1;
                end else begin
                    wbm_ack_i = 1'b1;
                    wbm_dat_i = rd_mem(wbm_adr_o);
                end
            end else begin
                wcnt--;
            end
        end else begin
            wcnt = $urandom_range(0, wait_max);
        end
    end

    always @(negedge clk)
        desc_ready = rdy_rand ? ($urandom_range(0, 2) == 0) : 1'b1;

    always @(posedge clk) begin
        if (!rst) begin
            if (wbm_cyc_o && wbm_stb_o && wbm_ack_i) rd_q.push_back(wbm_adr_o);
            if (desc_valid && desc_ready) hs_q.push_back({desc_ctl, desc_addr, desc_len});
            if (ndar_dirty_clear) dclr_cnt++;
            if (append_clear) aclr_cnt++;
        end
    end

    task automatic clear_logs();
        rd_q.delete();
        hs_q.delete();
        dclr_cnt = 0;
        aclr_cnt = 0;
    endtask

    task automatic wait_state(input logic [7:0] s, input string tag);
        for (int i = 0; i < 3000 && ctrl_state !== s; i++) @(negedge clk);
        chk(tag, 32'(ctrl_state), 32'(s));
    endtask

    task automatic start_chain(input logic [31:0] start, input bit timing);
        int cnt;
        @(negedge clk);
        ndar = start[31:3];
        ndar_dirty = 1'b1;
        enable = 1'b1;
        cnt = 0;
        while (!wbm_stb_o && cnt < 100) begin
            @(negedge clk);
            cnt++;
            if (ndar_dirty_clear) ndar_dirty = 1'b0;
        end
        ndar_dirty = 1'b0;
        if (timing) begin
            chk("stb_latency", 32'(cnt), 32'd2);
            while (!desc_valid && cnt < 100) begin
                @(negedge clk);
                cnt++;
            end
            chk("valid_latency", 32'(cnt), 32'd9);
        end
    endtask

    task automatic serve(input int n);
        for (int i = 0; i < n; i++) begin
            wait_state(8'd3, "wait_run");
            repeat ($urandom_range(0, 3)) @(negedge clk);
            desc_done = 1'b1;
            @(negedge clk);
            desc_done = 1'b0;
        end
    endtask

    task automatic check_result(input string tag);
        int n;
        wait_state(8'd5, {tag, "_halt"});
        chk({tag, "_nreads"}, 32'(rd_q.size()), 32'(exp_rd.size()));
        n = (rd_q.size() < exp_rd.size()) ? rd_q.size() : exp_rd.size();
        for (int i = 0; i < n; i++) chk({tag, "_rd_adr"}, rd_q[i], exp_rd[i]);
        chk({tag, "_nhs"}, 32'(hs_q.size()), 32'(exp_hs.size()));
        n = (hs_q.size() < exp_hs.size()) ? hs_q.size() : exp_hs.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_ctl"},  32'(hs_q[i].ctl), 32'(exp_hs[i].ctl));
            chk({tag, "_addr"}, hs_q[i].addr, exp_hs[i].addr);
            chk({tag, "_len"},  32'(hs_q[i].len), 32'(exp_hs[i].len));
        end
        chk({tag, "_dar"}, dar, exp_dar);
        chk({tag, "_next"}, 32'(next_desc), 32'(exp_next));
        chk({tag, "_csr"}, 32'(csr), 32'h01);
        chk({tag, "_int"}, 32'(wb_int_o), 32'(exp_int));
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic go_idle();
        @(negedge clk);
        enable = 1'b0;
        wait_state(8'd0, "to_idle");
        wb_int_clear = 1'b1;
        @(negedge clk);
        wb_int_clear = 1'b0;
        chk("int_cleared", 32'(wb_int_o), 32'd0);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a [4];
        int n;
        exp_clear();

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_state", 32'(ctrl_state), 32'd0);
        chk("rst_cyc", 32'({wbm_cyc_o, wbm_stb_o}), 32'd0);
        chk("rst_dar", dar, 32'd0);
        chk("rst_csr", 32'(csr), 32'd0);
        chk("rst_busy_int", 32'({busy, wb_int_o, desc_valid}), 32'd0);
        chk("rst_pulses", 32'({ndar_dirty_clear, append_clear}), 32'd0);
        chk("rst_next", 32'(next_desc), 32'd0);
        chk("bus_const", 32'({wbm_we_o, wbm_sel_o}), 32'h0f);
        rst = 1'b0;

        // Single descriptor, zero wait states, timing checked
        put_desc(32'h1000, 32'h0000_0001, 32'h0001_0042, 32'h2000, 32'h100);
        wait_max = 0;
        rdy_rand = 1'b0;
        clear_logs();
        exp_clear();
        walk(32'h1000);
        start_chain(32'h1000, 1'b1);
        serve(exp_hs.size());
        check_result("single");
        chk("single_dclr", 32'(dclr_cnt), 32'd1);
        go_idle();

        // Chain of three, no interrupts
        put_desc(32'h8000, 32'h8100, 32'h0000_0011, 32'hA000, 32'h10);
        put_desc(32'h8100, 32'h8200, 32'h0000_0022, 32'hA100, 32'h20);
        put_desc(32'h8200, 32'h0000_0001, 32'h0000_0033, 32'hA200, 32'h30);
        wait_max = 2;
        rdy_rand = 1'b1;
        clear_logs();
        exp_clear();
        walk(32'h8000);
        start_chain(32'h8000, 1'b0);
        serve(exp_hs.size());
        check_result("chain3");

        // Append from HALT: word0 of the halted descriptor now points on
        put_desc(32'h3000, 32'h0000_0001, 32'h0001_0033, 32'hB000, 32'h44);
        mem[32'h8200] = 32'h3000;
        clear_logs();
        exp_clear();
        exp_rd.push_back(32'h8200);
        walk(32'h3000);
        @(negedge clk);
        append = 1'b1;
        for (int i = 0; i < 100 && !append_clear; i++) @(negedge clk);
        append = 1'b0;
        serve(exp_hs.size());
        check_result("append");
        chk("append_aclr", 32'(aclr_cnt), 32'd1);

        // Append while word0 still marks end of chain: one read, stay halted
        clear_logs();
        exp_clear();
        exp_rd.push_back(32'h3000);
        exp_dar  = 32'h3000;
        exp_next = 29'd0;
        exp_int  = 1'b1;
        @(negedge clk);
        append = 1'b1;
        for (int i = 0; i < 100 && !append_clear; i++) @(negedge clk);
        append = 1'b0;
        for (int i = 0; i < 100 && rd_q.size() == 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check_result("append_eoc");
        go_idle();

        // Beat offset wrapping past 2^32
        put_desc(32'hFFFF_FFF8, 32'h0000_0001, 32'h0000_0055, 32'hC000, 32'hFF_FFFF);
        wait_max = 1;
        clear_logs();
        exp_clear();
        walk(32'hFFFF_FFF8);
        start_chain(32'hFFFF_FFF8, 1'b0);
        serve(exp_hs.size());
        check_result("wrap");
        go_idle();

        // Randomised chains
        for (int t = 0; t < 6; t++) begin
            n = $urandom_range(1, 4);
            for (int i = 0; i < 4; i++)
                a[i] = 32'h4000_0000 + 32'(t * 32'h1000) + 32'(i * 32'h40)
                       + 32'($urandom_range(0, 3) << 3);
            for (int i = 0; i < n; i++)
                put_desc(a[i],
                         (i < n - 1) ? {a[i+1][31:3], 2'($urandom_range(0, 3)), 1'b0}
                                     : ($urandom() | 32'd1),
                         $urandom(), $urandom(), $urandom());
            wait_max = $urandom_range(0, 3);
            rdy_rand = $urandom_range(0, 1) == 1;
            clear_logs();
            exp_clear();
            walk(a[0]);
            start_chain(a[0], 1'b0);
            serve(exp_hs.size());
            check_result("rand");
            chk("rand_dclr", 32'(dclr_cnt), 32'd1);
            go_idle();
        end

        // Bus error on the third beat
        put_desc(32'h5000, 32'h0000_0001, 32'h0001_0001, 32'hD000, 32'h8);
        err_en = 1'b1;
        err_addr = 32'h5008;
        clear_logs();
        start_chain(32'h5000, 1'b0);
        wait_state(8'd7, "buserr_state");
        chk("buserr_csr", 32'(csr), 32'h02);
        chk("buserr_int", 32'(wb_int_o), 32'd1);
        chk("buserr_busy_cyc", 32'({busy, wbm_cyc_o}), 32'd0);
        chk("buserr_nreads", 32'(rd_q.size()), 32'd2);
        if (rd_q.size() == 2) chk("buserr_rd1", rd_q[1], 32'h5004);
        enable = 1'b0;
        wait_state(8'd0, "buserr_idle");
        chk("buserr_csr_clr", 32'(csr), 32'h00);
        err_en = 1'b0;
        go_idle();

        // Descriptor error, interrupt clear on the set edge
        put_desc(32'h6000, 32'h0000_0001, 32'h0000_0077, 32'hE000, 32'h9);
        clear_logs();
        start_chain(32'h6000, 1'b0);
        wait_state(8'd3, "derr_run");
        desc_done = 1'b1;
        desc_err = 1'b1;
        wb_int_clear = 1'b1;
        @(negedge clk);
        desc_done = 1'b0;
        desc_err = 1'b0;
        wb_int_clear = 1'b0;
        chk("derr_state", 32'(ctrl_state), 32'd7);
        chk("derr_csr", 32'(csr), 32'h04);
        chk("derr_int", 32'(wb_int_o), 32'd1);
        enable = 1'b0;
        wait_state(8'd0, "derr_idle");
        chk("derr_csr_clr", 32'(csr), 32'h00);
        chk("derr_int_held", 32'(wb_int_o), 32'd1);
        go_idle();

        // Enable dropped mid-fetch: outstanding beat completes, then IDLE
        wait_max = 3;
        put_desc(32'h7000, 32'h0000_0001, 32'h0000_0001, 32'hF000, 32'h1);
        clear_logs();
        start_chain(32'h7000, 1'b0);
        enable = 1'b0;
        wait_state(8'd0, "endrop_idle");
        chk("endrop_nreads", 32'(rd_q.size()), 32'd1);
        chk("endrop_nhs", 32'(hs_q.size()), 32'd0);
        chk("endrop_busy_cyc", 32'({busy, wbm_cyc_o}), 32'd0);

        // Reset in the middle of a stalled beat
        hold = 1'b1;
        clear_logs();
        start_chain(32'h1000, 1'b0);
        chk("midrst_stb_up", 32'(wbm_stb_o), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_cyc", 32'({wbm_cyc_o, wbm_stb_o}), 32'd0);
        chk("midrst_state", 32'(ctrl_state), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_dar", dar, 32'd0);
        rst = 1'b0;
        hold = 1'b0;
        enable = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dma_desc_ctl.md
# dma_desc_ctl

Descriptor-chain controller for the DMA engine: it consumes the host-programmed control bits (enable, append, ndar, ndar_dirty) from the Wishbone slave register block, and fetches 4-word descriptors from memory over a Wishbone master port. It hands each descriptor to the data mover through a valid/ready handshake, then follows the chain. It returns status (dar, csr, busy, wb_int_o, next_desc, ctrl_state) and the ndar_dirty_clear/append_clear pulses to the register block.

## Interface
Parameters: none. Descriptor layout is fixed. A descriptor sits at an 8-byte-aligned address A:
- word0 @A: [31:3] next pointer; [0] EOC, end of chain.
- word1 @A+4: [15:0] ctl; [16] int_en.
- word2 @A+8: buffer address.
- word3 @A+12: [23:0] length.

Ports:
- wb_clk_i  in  1  sole clock
- wb_rst_i  in  1  reset, synchronous, active-high
- enable  in  1  run enable
- append  in  1  host appended to halted chain
- ndar  in  [31:3]  new descriptor address
- ndar_dirty  in  1  ndar holds an unconsumed value
- wb_int_clear  in  1  one-cycle interrupt clear
- ndar_dirty_clear  out  1  one-cycle pulse, ndar consumed
- append_clear  out  1  one-cycle pulse, append consumed
- dar  out  32  address of current descriptor
- next_desc  out  [31:3]  word0[31:3] of last fetched descriptor
- csr  out  8  [0] halted at EOC, [1] bus error, [2] descriptor error, [7:3] 0
- busy  out  1  state not IDLE/HALT/ERROR
- wb_int_o  out  1  interrupt pending
- ctrl_state  out  8  encoded state, zero-extended
- wbm_adr_o  out  32  read address
- wbm_cyc_o, wbm_stb_o  out  1  bus request
- wbm_we_o  out  1  constant 0
- wbm_sel_o  out  4  constant 4'hf
- wbm_dat_i  in  32  read data
- wbm_ack_i, wbm_err_i  in  1  bus termination
- desc_valid  out  1  descriptor offered
- desc_ready  in  1  data mover accepts
- desc_ctl  out  16; desc_addr  out  32; desc_len  out  24  descriptor fields, stable while desc_valid
- desc_done  in  1  one-cycle pulse, transfer complete
- desc_err  in  1  qualifies desc_done as failed

## Operation
State encodings are IDLE=0, FETCH=1, ISSUE=2, RUN=3, NEXT=4, HALT=5, RELOAD=6, ERROR=7.
- IDLE: if enable && ndar_dirty: dar<={ndar,3'b0}, pulse ndar_dirty_clear, word index<=0, go FETCH.
- FETCH: single reads at dar+4*idx, idx 0..3. Each ack latches the addressed word and increments idx. The fourth ack goes to ISSUE. wbm_err_i goes to ERROR and sets csr[1].
- ISSUE: desc_valid=1 until sampled with desc_ready=1, then RUN.
- RUN: wait for desc_done. If desc_err=1: set csr[2], go ERROR. Otherwise, if int_en then set wb_int_o; go NEXT.
- NEXT: if !enable go IDLE. Else if EOC=0: dar<={next,3'b0}, go FETCH. Else set csr[0], go HALT.
- HALT: if !enable go IDLE. Else if ndar_dirty: load ndar as in IDLE, clear csr[0], go FETCH. Else if append: pulse append_clear, go RELOAD.
- RELOAD: a single read of word0 at dar updates next and EOC. If EOC=0: clear csr[0], dar<={next,3'b0}, go FETCH. If EOC=1 go HALT. A bus error goes to ERROR.
- ERROR: wb_int_o set on entry. Stay until enable=0, then clear csr[2:1] and go IDLE.
- enable falling in FETCH/RELOAD: finish the outstanding beat, then go IDLE. In ISSUE: hold until accepted. In RUN: wait for done. No abort of in-flight transfers.
- wb_int_o: a set and wb_int_clear in the same cycle leave it set.
- An ndar_dirty pulse arriving while busy is ignored until IDLE/HALT.

## Timing
- Reset values: all outputs 0, state IDLE, dar=0, csr=0, next_desc=0. Reset mid-bus-cycle drops cyc/stb on the next edge.
- All outputs are registered. cyc/stb rise the cycle after entering FETCH/RELOAD and hold until ack/err. They fall the cycle after termination, with one idle cycle between beats. Zero-wait-state fetch therefore costs 8 cycles.
- Latency from ndar_dirty&&enable to first stb: 2 cycles. Fourth ack to desc_valid: 1 cycle. Accept to RUN: next edge.
- Pulses ndar_dirty_clear and append_clear are exactly 1 cycle wide.
- dar arithmetic is 32-bit, low 3 bits always 0. The beat offset wraps modulo 2^32.

## Test plan
- Single descriptor: ndar=0x1000>>3, dirty, enable. Memory word0=0x00000001, word1=0x0001_0042, word2=0x2000, word3=0x100. Expect reads at 0x1000/04/08/0C, desc_ctl=0x42, desc_len=0x100. After desc_done: wb_int_o=1, csr=0x01, HALT.
- Chain of 3 descriptors with EOC on the last. Expect 12 reads, 3 handshakes, dar ending at the third address, no interrupts with int_en=0.
- Append: from HALT, memory word0 rewritten to 0x3000, append pulsed. Expect append_clear, one read at dar, then a fetch at 0x3000.
- Bus error on the third beat. Expect ERROR, csr=0x02, wb_int_o=1. Drop enable: IDLE, csr=0.
- desc_err with done. Expect csr[2]=1, ERROR. wb_int_clear together with the set edge: wb_int_o stays 1.
- Reset asserted mid-FETCH with stb high. Next cycle: cyc/stb=0, state 0, busy 0.
